// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and response error causes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } lsu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_FAULT    = 2'd2,
    CAUSE_ILLEGAL  = 2'd3
  } lsu_cause_e;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane helper: extracts and extends a sub-word load, and merges
// sub-word store data into a full memory word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = word;
    endcase

    // Full-word stores bypass the merge entirely, so default passes wdata.
    merged = word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: checks requests, extracts load lanes and
// performs sub-word stores as a read-modify-write on a word-only memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int XLEN      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_WORDS * 4);

  lsu_state_e  state;
  lsu_cause_e  cause;
  logic [31:0] rmw_addr;
  logic [31:0] rmw_word;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        accept;
  logic        req_err;
  logic        is_word;

  // Checks in priority order: illegal funct3, then misalignment, then range.
  always_comb begin
    cause = CAUSE_NONE;
    if (req_write ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                  : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      cause = CAUSE_ILLEGAL;
    else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
             (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
      cause = CAUSE_MISALIGN;
    else if (req_addr >= MEM_LIMIT)
      cause = CAUSE_FAULT;
  end

  assign req_ready = !rst && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = (cause != CAUSE_NONE);
  assign is_word   = (req_funct3 == F3_W);

  assign mem_read  = accept && !req_err && !(req_write && is_word);
  assign mem_write = (!rst && state == RMW_WR) ||
                     (accept && !req_err && req_write && is_word);
  assign mem_addr  = (state == RMW_WR) ? rmw_addr : {req_addr[31:2], 2'b00};
  assign mem_wdata = (state == RMW_WR) ? rmw_word : req_wdata;

  lsu_lane u_lane (
    .word      (mem_rdata),
    .wdata     (req_wdata),
    .offset    (req_addr[1:0]),
    .funct3    (req_funct3),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_cause <= CAUSE_NONE;
      rmw_addr   <= '0;
      rmw_word   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              resp_cause <= cause;
            end else if (req_write && !is_word) begin
              rmw_addr <= {req_addr[31:2], 2'b00};
              rmw_word <= merged;
              state    <= RMW_WR;
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= req_write ? '0 : load_data;
              resp_err   <= 1'b0;
              resp_cause <= CAUSE_NONE;
            end
          end
        end
        RMW_WR: begin
          state      <= IDLE;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_cause <= CAUSE_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests checked
// against a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  resp_cause;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init;
  int          wr_count;
  int          rd_count;
  int          vectors = 0;
  int          miscompares = 0;

  load_store_unit #(.MEM_WORDS(256), .XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .resp_cause (resp_cause),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A00C300;
  endfunction

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      wr_count <= 0;
      rd_count <= 0;
    end else begin
      if (mem_write) begin
        mem[mem_addr[9:2]] <= mem_wdata;
        wr_count <= wr_count + 1;
      end
      if (mem_read) rd_count <= rd_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_size(logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] ref_cause(logic w, logic [2:0] f3, logic [31:0] a);
    bit legal;
    if (w) legal = (f3 <= 3'd2);
    else   legal = (f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5;
    if (!legal) return 2'd3;
    if (a % ref_size(f3) != 0) return 2'd1;
    if (a >= 32'd1024) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [2:0] f3);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(a % 4);
    v  = ref_mem[a[9:2]] >> sh;
    if (ref_size(f3) == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (ref_size(f3) == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    sh = 8 * int'(a % 4);
    if (ref_size(f3) == 4) begin
      ref_mem[a[9:2]] = wd;
    end else begin
      mask = ((ref_size(f3) == 1) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[a[9:2]] = (ref_mem[a[9:2]] & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Issues one request in the current cycle and checks its full response.
  task automatic applyStimulus(input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd);
    logic [1:0]  c;
    logic [31:0] exp_data;
    bit          sub;
    int          wr0, rd0;
    c        = ref_cause(w, f3, a);
    sub      = (c == 2'd0) && w && (ref_size(f3) < 4);
    exp_data = (c == 2'd0 && !w) ? ref_load(a, f3) : 32'h0;
    wr0 = wr_count;
    rd0 = rd_count;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (sub) begin
      checkOutput("rmw_ready", 32'(req_ready), 32'd0);
      checkOutput("rmw_valid", 32'(resp_valid), 32'd0);
      checkOutput("rmw_strobe", 32'(mem_write), 32'd1);
      @(posedge clk);
      #1;
    end
    if (c == 2'd0 && w) ref_store(a, f3, wd);
    checkOutput("resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("resp_err", 32'(resp_err), 32'(c != 2'd0));
    checkOutput("resp_cause", 32'(resp_cause), 32'(c));
    checkOutput("resp_rdata", resp_rdata, exp_data);
    checkOutput("mem_writes", 32'(wr_count - wr0), 32'((c == 2'd0 && w) ? 1 : 0));
    checkOutput("mem_reads", 32'(rd_count - rd0),
                32'((c == 2'd0 && !(w && ref_size(f3) == 4)) ? 1 : 0));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired before completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          bad;
    int          wr0;
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_err", 32'(resp_err), 32'd0);
    checkOutput("reset_cause", 32'(resp_cause), 32'd0);
    checkOutput("reset_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_strobes", 32'({mem_read, mem_write}), 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(posedge clk);
    #1;

    // Load extraction on a known word, back to back.
    applyStimulus(1'b1, 3'b010, 32'h40, 32'h80FF7F01);
    applyStimulus(1'b0, 3'b000, 32'h43, 32'h0);
    checkOutput("lb_const", resp_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h43, 32'h0);
    checkOutput("lbu_const", resp_rdata, 32'h00000080);
    applyStimulus(1'b0, 3'b001, 32'h42, 32'h0);
    checkOutput("lh_const", resp_rdata, 32'hFFFF80FF);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0);
    checkOutput("lw_const", resp_rdata, 32'h80FF7F01);

    // Sub-word store read-modify-write, then read back.
    applyStimulus(1'b1, 3'b010, 32'h40, 32'h11223344);
    applyStimulus(1'b1, 3'b000, 32'h41, 32'h000000AB);
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0);
    checkOutput("sb_merge_const", resp_rdata, 32'h1122AB44);

    // Error paths.
    applyStimulus(1'b1, 3'b001, 32'h41, 32'hCAFE);
    applyStimulus(1'b0, 3'b010, 32'h402, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h400, 32'h0);
    checkOutput("fault_const", 32'(resp_cause), 32'd2);
    applyStimulus(1'b0, 3'b011, 32'h40, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h40, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h41, 32'h0);
    checkOutput("illegal_prio_const", 32'(resp_cause), 32'd3);

    applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);
    checkOutput("raw_const", resp_rdata, 32'hDEADBEEF);

    // Reset while a read-modify-write is pending must drop the write.
    wr0 = wr_count;
    req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20;
    req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("abort_in_rmw", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("abort_no_strobe", 32'(mem_write), 32'd0);
    checkOutput("abort_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(req_ready), 32'd1);
    checkOutput("abort_valid", 32'(resp_valid), 32'd0);
    checkOutput("abort_writes", 32'(wr_count - wr0), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_valid_later", 32'(resp_valid), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("pulse_width", 32'(resp_valid), 32'd0);

    for (int n = 0; n < 300; n++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(1024, 1100));
      else                           a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a - (a % ref_size(f3));
      applyStimulus(w, f3, a, $urandom);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checkOutput("memscan", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
